// File: rtl/data_mem_ctrl.sv
// Byte/half/word data memory behind a valid/ready request/response handshake.
// Latency: response valid READ_LAT cycles after accept; one transaction in flight.
// Backpressure: response held until rsp_ready; req_ready low from accept to response completion.
module data_mem_ctrl #(
  parameter int DEPTH    = 128,
  parameter int ADDR_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  // WAIT leaves when the counter reaches READ_LAT-2 (WAIT is never entered for READ_LAT=1)
  localparam int         LAST     = (READ_LAT > 1) ? READ_LAT - 2 : 0;
  localparam logic [1:0] CNT_LAST = LAST[1:0];

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [1:0]        lat_cnt;
  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] addr_hi;
  logic              err;
  logic [3:0]        wbe;
  logic [31:0]       wword;
  logic [31:0]       rword;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;
  logic [31:0]       rload;

  assign idx     = req_addr[IDX_W+1:2];
  assign lane    = req_addr[1:0];
  // any bit above the word index means the word index is >= DEPTH
  assign addr_hi = req_addr >> (IDX_W + 2);
  assign accept  = req_valid && req_ready;

  // Error classification: illegal size, misalignment, out of range
  always_comb begin
    err = 1'b0;
    case (req_size)
      2'b00:   err = 1'b0;
      2'b01:   err = lane[0];
      2'b10:   err = (lane != 2'b00);
      default: err = 1'b1;
    endcase
    if (addr_hi != '0) err = 1'b1;
  end

  // Store lane enables and lane-replicated write data
  always_comb begin
    wbe   = 4'b0000;
    wword = req_wdata;
    case (req_size)
      2'b00: begin
        wbe   = 4'b0001 << lane;
        wword = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        wbe   = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{req_wdata[15:0]}};
      end
      2'b10:   wbe = 4'b1111;
      default: wbe = 4'b0000;
    endcase
  end

  assign rword = mem[idx];
  assign rbyte = rword[{lane, 3'b000} +: 8];
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

  // Load lane select and sign/zero extension
  always_comb begin
    rload = rword;
    case (req_size)
      2'b00:   rload = req_signed ? {{24{rbyte[7]}}, rbyte} : {24'h0, rbyte};
      2'b01:   rload = req_signed ? {{16{rhalf[15]}}, rhalf} : {16'h0, rhalf};
      default: rload = rword;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs; req_ready is forced low while in reset
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst_n;
        if (req_valid && rst_n) state_nxt = (READ_LAT == 1) ? RESP : WAIT;
      end
      WAIT: begin
        if (lat_cnt == CNT_LAST) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latency counter runs only while waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              lat_cnt <= '0;
    else if (state == WAIT)  lat_cnt <= lat_cnt + 2'd1;
    else                     lat_cnt <= '0;
  end

  // Response captured at accept and held until the response completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_err   <= err;
      rsp_rdata <= (err || req_we) ? 32'h0 : rload;
    end
  end

  // Array write at the accept edge; contents survive reset
  always_ff @(posedge clk) begin
    if (accept && req_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (wbe[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: READ_LAT=1 and READ_LAT=3 instances driven in turn.
// Byte-array reference model; directed cases, backpressure, reset abort, random traffic.
// Every comparison goes through chk.
module tb_data_mem_ctrl;

  localparam int DEPTH = 128;
  localparam int NW    = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [1:0]  req_size  [2];
  logic        req_signed[2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int          lat[2];
  int          n_vec = 0;
  int          n_err = 0;

  logic [7:0]  mb[2][DEPTH*4];
  logic [31:0] exp_rdata[2];
  logic        exp_err[2];
  logic [31:0] last_rdata[2];
  logic        last_err[2];

  data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .READ_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .READ_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: memory as a little-endian byte array, rules applied directly
  task automatic model(input int d, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    int     nb;
    longint v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (sz == 2'd3 || (a % nb) != 0 || (a / 4) >= DEPTH) begin
      exp_err[d]   = 1'b1;
      exp_rdata[d] = 32'h0;
    end else if (we) begin
      for (int i = 0; i < nb; i++) mb[d][int'(a) + i] = wd[8*i +: 8];
      exp_err[d]   = 1'b0;
      exp_rdata[d] = 32'h0;
    end else begin
      v = 0;
      for (int i = 0; i < nb; i++) v = v + (longint'(mb[d][int'(a) + i]) << (8 * i));
      if (sg && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
      exp_err[d]   = 1'b0;
      exp_rdata[d] = v[31:0];
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge
  task automatic issue(input int d, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = 0;
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_size[d]   = sz;
    req_signed[d] = sg;
    req_addr[d]   = a;
    req_wdata[d]  = wd;
    while (req_ready[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
    @(posedge clk);
    model(d, we, sz, sg, a, wd);
    @(negedge clk);
    // scramble inputs: the captured request must not follow them
    req_valid[d]  = 1'b0;
    req_we[d]     = 1'($urandom);
    req_size[d]   = 2'($urandom);
    req_signed[d] = 1'($urandom);
    req_addr[d]   = $urandom;
    req_wdata[d]  = $urandom;
  endtask

  task automatic wait_rsp(input int d);
    int k;
    k = 1;
    while (rsp_valid[d] !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'(lat[d]));
  endtask

  task automatic finish_rsp(input int d, input int hold, input logic bp);
    logic [31:0] r0;
    r0 = rsp_rdata[d];
    chk("rdata", rsp_rdata[d], exp_rdata[d]);
    chk("err", 32'(rsp_err[d]), 32'(exp_err[d]));
    last_rdata[d] = rsp_rdata[d];
    last_err[d]   = rsp_err[d];
    for (int i = 0; i < hold; i++) begin
      if (bp) begin
        req_valid[d] = 1'b1;
        req_we[d]    = 1'b0;
        req_size[d]  = 2'd2;
        req_addr[d]  = 32'h14;
      end
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
      chk("hold_rdata", rsp_rdata[d], r0);
      chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    chk("rsp_done", 32'(rsp_valid[d]), 32'd0);
    chk("ready_after", 32'(req_ready[d]), 32'd1);
  endtask

  task automatic do_txn(input int d, input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        input logic bp);
    issue(d, we, sz, sg, a, wd);
    wait_rsp(d);
    finish_rsp(d, hold, bp);
  endtask

  task automatic run_dut(input int d);
    logic [31:0] a;
    logic [31:0] v;
    int          r;
    for (int w = 0; w < NW; w++) do_txn(d, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 0, 1'b0);

    do_txn(d, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    do_txn(d, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b0);
    chk("ld_deadbeef", last_rdata[d], 32'hDEADBEEF);
    do_txn(d, 1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_0080, 0, 1'b0);
    do_txn(d, 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 0, 1'b0);
    chk("ld_byte_s", last_rdata[d], 32'hFFFFFF80);
    do_txn(d, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1, 1'b0);
    chk("ld_byte_u", last_rdata[d], 32'h00000080);
    do_txn(d, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b0);
    chk("ld_merged", last_rdata[d], 32'hDEAD80EF);
    do_txn(d, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, 1'b0);
    chk("ld_half_s", last_rdata[d], 32'hFFFFDEAD);
    do_txn(d, 1'b1, 2'd1, 1'b0, 32'h13, 32'h1234, 0, 1'b0);
    chk("st_half_mis", 32'(last_err[d]), 32'd1);
    do_txn(d, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b0);
    chk("unchanged", last_rdata[d], 32'hDEAD80EF);
    do_txn(d, 1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 0, 1'b0);
    chk("ld_word_mis", {last_rdata[d][31:1], last_err[d]}, 32'h1);
    do_txn(d, 1'b1, 2'd2, 1'b0, 32'h200, 32'hA5A5A5A5, 0, 1'b0);
    chk("st_oor", 32'(last_err[d]), 32'd1);
    do_txn(d, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0, 1'b0);

    // backpressure with a second request pending throughout
    do_txn(d, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, 1'b1);
    do_txn(d, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(9, 0);
      a = 32'($urandom_range(NW * 4 - 1, 0));
      if (r == 0) a = 32'h200 + 32'($urandom_range(255, 0));
      if (r == 1) a = 32'h8000_0000 | a;
      do_txn(d, 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
             $urandom_range(2, 0), 1'b0);
    end

    // reset while the response is waiting: store must persist
    v = $urandom;
    issue(d, 1'b1, 2'd2, 1'b0, 32'h20, v);
    wait_rsp(d);
    rst_n[d] = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    chk("rst_req_ready", 32'(req_ready[d]), 32'd0);
    @(negedge clk);
    rst_n[d] = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready[d]), 32'd1);
    do_txn(d, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, 1'b0);
    chk("aborted_store", last_rdata[d], v);
  endtask

  initial begin
    lat[0] = 1;
    lat[1] = 3;
    for (int d = 0; d < 2; d++) begin
      rst_n[d]      = 1'b1;
      req_valid[d]  = 1'b0;
      req_we[d]     = 1'b0;
      req_size[d]   = 2'd0;
      req_signed[d] = 1'b0;
      req_addr[d]   = 32'h0;
      req_wdata[d]  = 32'h0;
      rsp_ready[d]  = 1'b0;
    end
    #1;
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("reset_req_ready", 32'(req_ready[d]), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata[d], 32'h0);
      chk("reset_rsp_err", 32'(rsp_err[d]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    run_dut(0);
    run_dut(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
